alu_pipe_core: RTL
==================

// Module: alu_pipe_core
// PURPOSE
//  Parametrised, pipelined signed-integer ALU with valid/ready handshake on both sides.
//  - Per-result exception/overflow/underflow flags, optional saturation, sticky flag register.
//  - Next generation of the single-cycle ALU datapath; sits between operand issue logic and
//    result writeback, and absorbs writeback backpressure without dropping operations.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=8)
//  STAGES  3   pipeline register stages, input to output (>=1)
// PORTS
//  clk          in   1      single clock; all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      operand bundle valid
//  in_ready     out  1      core accepts bundle this cycle
//  a_operand    in   WIDTH  operand A (signed)
//  b_operand    in   WIDTH  operand B (signed)
//  Operation    in   4      opcode (see BEHAVIOUR)
//  sat_en       in   1      saturate ADD/SUB/MUL on overflow/underflow; sampled with operands
//  out_valid    out  1      result bundle valid
//  out_ready    in   1      consumer accepts result
//  ALU_Output   out  WIDTH  result
//  Exception    out  1      illegal opcode
//  Overflow     out  1      signed result above max (before saturation)
//  Underflow    out  1      signed result below min (before saturation)
//  sticky_flags out  3      {Exception,Overflow,Underflow}, ORed over delivered results
//  sticky_clr   in   1      clear sticky_flags
// BEHAVIOUR
//  - Reset: all stage valid bits 0; out_valid=0; ALU_Output=0; Exception/Overflow/Underflow=0;
//    sticky_flags=0. In-flight operations are discarded, including on reset mid-operation.
//  - Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL, 9 SLT, 10 MIN, 11 MAX.
//    - MUL keeps the low WIDTH bits.
//    - Shift amount is b_operand[$clog2(WIDTH)-1:0].
//    - SLT returns 1/0.
//    - MIN/MAX are signed comparisons.
//  - Opcodes 12..15: ALU_Output=0, Exception=1, Overflow=Underflow=0.
//  - Flags:
//    - ADD/SUB/MUL compute the exact signed result.
//    - Overflow=1 if result > 2^(W-1)-1; Underflow=1 if result < -2^(W-1).
//    - All other ops: Overflow=Underflow=0.
//    - sat_en=1: out-of-range result clamps to max/min; flag still reported.
//    - sat_en=0: result wraps (low W bits).
//  - Compute happens combinationally on the accepted bundle and is captured in stage 1.
//    Stages 2..STAGES carry result and flags unchanged.
//  - Handshake:
//    - en = !out_valid || out_ready; in_ready = en.
//    - All stages advance together when en=1; the whole pipe holds when en=0.
//    - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//    - A stage with valid=0 loads a bubble when in_valid=0 and en=1.
//    - Latency: exactly STAGES cycles, accept edge to out_valid, when out_ready is held high.
//    - Throughput: 1 op/cycle.
//  - Output bundle (ALU_Output, flags) stays stable while out_valid && !out_ready.
//  - Results leave in acceptance order; no drop, no duplication.
//  - Sticky register:
//    - On each output transfer, sticky_flags |= {Exception,Overflow,Underflow}.
//    - sticky_clr=1 clears it next cycle.
//    - sticky_clr coincident with a flagged output transfer: the new flags are set (set wins).
//  - rst overrides every other input.
// STRUCTURE
//  - alu_pkg:
//    - op_e enum for the 4-bit opcodes.
//    - alu_flags_t packed struct {exception, overflow, underflow}.
//    - Constant OP_LAST_LEGAL=4'd11.
//  - Sub-module alu_comb_unit (combinational; WIDTH param; opcode/operands/sat_en -> result,
//    flags) feeds a generate-loop pipeline of STAGES valid+payload registers in alu_pipe_core.
// TESTING  (WIDTH=32, STAGES=3 unless noted)
//  1. ADD 0x7FFFFFFF+0x1, sat_en=0 -> ALU_Output=0x80000000, Overflow=1, out_valid 3 cycles
//     after accept. Same with sat_en=1 -> 0x7FFFFFFF, Overflow=1.
//  2. SUB 0x80000000-0x1, sat_en=1 -> 0x80000000, Underflow=1.
//     MUL 0x00010000*0x00010000, sat_en=0 -> 0x00000000, Overflow=1.
//  3. Operation=4'hD, a=5, b=7 -> ALU_Output=0, Exception=1, sticky_flags=3'b100.
//     Then sticky_clr=1 with an ADD 1+1 delivering -> ALU_Output=2, sticky_flags=3'b000.
//  4. Backpressure: 6 back-to-back ADDs (i+i, i=1..6), out_ready=0 for 5 cycles, then 1
//     -> in_ready low while stalled, output frozen, results 2,4,..,12 in order, none lost.
//  5. Reset mid-operation: rst=1 for 1 cycle with 2 ops in flight and sticky_flags=3'b010
//     -> next cycle out_valid=0, sticky_flags=0; the two results never appear.
//  6. STAGES=1, SRA 0x80000000 by 4 then SLT -3<2 -> 0xF8000000 then 0x1, latency 1 cycle,
//     no flags.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode, flag types and constants shared by the pipelined ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_MUL = 4'd8,
        OP_SLT = 4'd9,
        OP_MIN = 4'd10,
        OP_MAX = 4'd11
    } op_e;

    typedef struct packed {
        logic exception;
        logic overflow;
        logic underflow;
    } alu_flags_t;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd11;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_core_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_core_if
// Brief    : Operand-issue / result-writeback bundle for the pipelined ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_pipe_core_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_operand;
    logic [WIDTH-1:0] b_operand;
    logic [3:0]       Operation;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_Output;
    logic             Exception;
    logic             Overflow;
    logic             Underflow;
    logic [2:0]       sticky_flags;
    logic             sticky_clr;

    modport master (
        output in_valid, a_operand, b_operand, Operation, sat_en, out_ready, sticky_clr,
        input  in_ready, out_valid, ALU_Output, Exception, Overflow, Underflow, sticky_flags
    );

    modport slave (
        input  in_valid, a_operand, b_operand, Operation, sat_en, out_ready, sticky_clr,
        output in_ready, out_valid, ALU_Output, Exception, Overflow, Underflow, sticky_flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_comb_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_comb_unit
// Brief    : Combinational signed ALU with range flags and optional saturation.
// Revision : 1.0 - initial release
// ============================================================================
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [3:0]       i_op,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic             i_sat,
    output logic      [WIDTH-1:0] o_result,
    output alu_flags_t            o_flags
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_b_ext;
    logic [2*WIDTH-1:0]   w_mul;
    logic [SHW-1:0]       w_shamt;
    logic                 w_lt;
    logic [WIDTH-1:0]     w_raw;
    logic                 w_ovf;
    logic                 w_unf;
    logic                 w_exc;

    // One extra bit is enough to hold the exact sum/difference; the top two bits expose range.
    assign w_add   = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
    assign w_sub   = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
    assign w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_mul   = w_a_ext * w_b_ext;
    assign w_shamt = i_b[SHW-1:0];
    assign w_lt    = $signed(i_a) < $signed(i_b);

    always_comb begin
        w_raw = '0;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_exc = 1'b0;
        if (i_op > OP_LAST_LEGAL) begin
            w_exc = 1'b1;
        end else begin
            case (op_e'(i_op))
                OP_ADD: begin
                    w_raw = w_add[WIDTH-1:0];
                    w_ovf = (w_add[WIDTH:WIDTH-1] == 2'b01);
                    w_unf = (w_add[WIDTH:WIDTH-1] == 2'b10);
                end
                OP_SUB: begin
                    w_raw = w_sub[WIDTH-1:0];
                    w_ovf = (w_sub[WIDTH:WIDTH-1] == 2'b01);
                    w_unf = (w_sub[WIDTH:WIDTH-1] == 2'b10);
                end
                OP_AND: w_raw = i_a & i_b;
                OP_OR:  w_raw = i_a | i_b;
                OP_XOR: w_raw = i_a ^ i_b;
                OP_SLL: w_raw = i_a << w_shamt;
                OP_SRL: w_raw = i_a >> w_shamt;
                OP_SRA: w_raw = $signed(i_a) >>> w_shamt;
                OP_MUL: begin
                    // In range only when the upper half plus the result sign bit are all sign copies.
                    w_raw = w_mul[WIDTH-1:0];
                    w_ovf = !w_mul[2*WIDTH-1] && (w_mul[2*WIDTH-1:WIDTH-1] != '0);
                    w_unf =  w_mul[2*WIDTH-1] && (w_mul[2*WIDTH-1:WIDTH-1] != '1);
                end
                OP_SLT: w_raw = {{(WIDTH-1){1'b0}}, w_lt};
                OP_MIN: w_raw = w_lt ? i_a : i_b;
                OP_MAX: w_raw = w_lt ? i_b : i_a;
                default: w_exc = 1'b1;
            endcase
        end
    end

    always_comb begin
        o_result = w_raw;
        if (i_sat && w_ovf) begin
            o_result = MAX_VAL;
        end else if (i_sat && w_unf) begin
            o_result = MIN_VAL;
        end
        o_flags.exception = w_exc;
        o_flags.overflow  = w_ovf;
        o_flags.underflow = w_unf;
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_core
// Brief    : Pipelined signed ALU with valid/ready flow control and sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_pipe_core_if.slave  bus
);
    localparam int PW = WIDTH + 3;

    logic [WIDTH-1:0] w_result;
    alu_flags_t       w_flags;
    logic             w_en;
    logic             w_xfer_out;
    logic             r_valid [STAGES];
    logic [PW-1:0]    r_pay   [STAGES];
    logic [2:0]       r_sticky;

    alu_comb_unit #(
        .WIDTH (WIDTH)
    ) u_comb (
        .i_op     (bus.Operation),
        .i_a      (bus.a_operand),
        .i_b      (bus.b_operand),
        .i_sat    (bus.sat_en),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    // Single global enable: the whole pipe either advances or holds as one.
    assign w_en       = !r_valid[STAGES-1] || bus.out_ready;
    assign w_xfer_out = r_valid[STAGES-1] && bus.out_ready;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            if (s == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_valid[0] <= 1'b0;
                        r_pay[0]   <= '0;
                    end else if (w_en) begin
                        r_valid[0] <= bus.in_valid;
                        r_pay[0]   <= bus.in_valid ? {w_flags, w_result} : '0;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_valid[s] <= 1'b0;
                        r_pay[s]   <= '0;
                    end else if (w_en) begin
                        r_valid[s] <= r_valid[s-1];
                        r_pay[s]   <= r_pay[s-1];
                    end
                end
            end
        end
    endgenerate

    // A flagged delivery in the same cycle as a clear still leaves its flags set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 3'b000;
        end else if (w_xfer_out) begin
            r_sticky <= (bus.sticky_clr ? 3'b000 : r_sticky) | r_pay[STAGES-1][PW-1:WIDTH];
        end else if (bus.sticky_clr) begin
            r_sticky <= 3'b000;
        end
    end

    assign bus.in_ready     = w_en;
    assign bus.out_valid    = r_valid[STAGES-1];
    assign bus.ALU_Output   = r_pay[STAGES-1][WIDTH-1:0];
    assign bus.Exception    = r_pay[STAGES-1][WIDTH+2];
    assign bus.Overflow     = r_pay[STAGES-1][WIDTH+1];
    assign bus.Underflow    = r_pay[STAGES-1][WIDTH];
    assign bus.sticky_flags = r_sticky;

endmodule
`default_nettype wire
